// File: rtl/core_pkg.sv
// Shared core types: arbiter FSM states, requester identities and bus width.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory handshake bundle around the arbiter.
// slave = arbiter side; master = core requesters plus memory.
interface mem_arbiter_if;
  import core_pkg::*;

  logic            IF_REQ;
  logic [XLEN-1:0] IF_ADDR;
  logic            IF_FLUSH;
  logic            IF_ACK;
  logic [XLEN-1:0] IF_DATA;
  logic            CORE_STALL;

  logic            LS_REQ;
  logic            LS_WE;
  logic [XLEN-1:0] LS_ADDR;
  logic [XLEN-1:0] LS_WDATA;
  logic [BEW-1:0]  LS_BE;
  logic            LS_ACK;
  logic [XLEN-1:0] LS_RDATA;

  logic            MEM_REQ;
  logic            MEM_WE;
  logic [XLEN-1:0] MEM_ADDR;
  logic [XLEN-1:0] MEM_WDATA;
  logic [BEW-1:0]  MEM_BE;
  logic            MEM_GNT;
  logic            MEM_RVALID;
  logic [XLEN-1:0] MEM_RDATA;

  modport slave (
    input  IF_REQ, IF_ADDR, IF_FLUSH,
    output IF_ACK, IF_DATA, CORE_STALL,
    input  LS_REQ, LS_WE, LS_ADDR, LS_WDATA, LS_BE,
    output LS_ACK, LS_RDATA,
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
    input  MEM_GNT, MEM_RVALID, MEM_RDATA
  );

  modport master (
    output IF_REQ, IF_ADDR, IF_FLUSH,
    input  IF_ACK, IF_DATA, CORE_STALL,
    output LS_REQ, LS_WE, LS_ADDR, LS_WDATA, LS_BE,
    input  LS_ACK, LS_RDATA,
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
    output MEM_GNT, MEM_RVALID, MEM_RDATA
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One outstanding transaction; contending requesters are granted alternately.
module mem_arbiter
  import core_pkg::*;
(
  input logic          CLK,
  input logic          RSTN,
  mem_arbiter_if.slave bus_io
);

  function automatic arb_owner_t pick_owner(input logic if_req, input logic ls_req,
                                            input arb_owner_t last);
    if (if_req && ls_req) begin
      return (last == OWN_IF) ? OWN_LS : OWN_IF;
    end
    return if_req ? OWN_IF : OWN_LS;
  endfunction

  arb_state_t      state_q, state_d;
  arb_owner_t      own_q, own_d, last_q, last_d, grant_own;
  logic            flush_q, flush_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]  mem_be_q, mem_be_d;
  logic            if_ack_q, if_ack_d;
  logic            ls_ack_q, ls_ack_d;
  logic [XLEN-1:0] if_data_q, if_data_d;
  logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;
  logic            any_req;
  logic            if_ack;

  assign any_req   = bus_io.IF_REQ | bus_io.LS_REQ;
  assign grant_own = pick_owner(bus_io.IF_REQ, bus_io.LS_REQ, last_q);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      own_q       <= OWN_IF;
      last_q      <= OWN_LS;
      flush_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_data_q   <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      last_q      <= last_d;
      flush_q     <= flush_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      if_data_q   <= if_data_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (bus_io.MEM_GNT) state_d = WAIT;
      WAIT:    if (bus_io.MEM_RVALID) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own_d       = own_q;
    last_d      = last_q;
    flush_d     = flush_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_data_d   = if_data_q;
    ls_rdata_d  = ls_rdata_q;
    // A redirect only matters while a fetch is actually in flight.
    if (state_q != IDLE && own_q == OWN_IF && bus_io.IF_FLUSH) flush_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          own_d     = grant_own;
          last_d    = grant_own;
          mem_req_d = 1'b1;
          if (grant_own == OWN_IF) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus_io.IF_ADDR;
            mem_wdata_d = '0;
            mem_be_d    = {BEW{1'b1}};
          end else begin
            mem_we_d    = bus_io.LS_WE;
            mem_addr_d  = bus_io.LS_ADDR;
            mem_wdata_d = bus_io.LS_WDATA;
            mem_be_d    = bus_io.LS_BE;
          end
        end
      end
      ISSUE: if (bus_io.MEM_GNT) mem_req_d = 1'b0;
      WAIT: begin
        if (bus_io.MEM_RVALID) begin
          if (own_q == OWN_IF) begin
            if_data_d = bus_io.MEM_RDATA;
            if_ack_d  = 1'b1;
          end else begin
            ls_rdata_d = bus_io.MEM_RDATA;
            ls_ack_d   = 1'b1;
          end
        end
      end
      RESP:    flush_d = 1'b0;
      default: ;
    endcase
  end

  // Flushed fetches still complete on the memory side; only the ACK is hidden.
  assign if_ack = if_ack_q & ~flush_q;

  assign bus_io.IF_ACK     = if_ack;
  assign bus_io.IF_DATA    = if_data_q;
  assign bus_io.CORE_STALL = bus_io.IF_REQ & ~if_ack;
  assign bus_io.LS_ACK     = ls_ack_q;
  assign bus_io.LS_RDATA   = ls_rdata_q;
  assign bus_io.MEM_REQ    = mem_req_q;
  assign bus_io.MEM_WE     = mem_we_q;
  assign bus_io.MEM_ADDR   = mem_addr_q;
  assign bus_io.MEM_WDATA  = mem_wdata_q;
  assign bus_io.MEM_BE     = mem_be_q;

endmodule
